// File: rtl/feat_wr_pkg.sv
// Shared definitions for the feature-word AXI writer.
//   - AXI constants used on the AW channel and for B-response decoding
//   - FSM state encoding of the writer
//   - beat count of one full HOG feature frame
//   - burst_beats(): beats in the next burst (remaining words, capped at the burst size)
package feat_wr_pkg;

  localparam logic [2:0] AXSIZE_64B = 3'b110;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // 31 bins x 64 words
  localparam int unsigned FULL_FRAME_BEATS = 32'd1984;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } wr_state_e;

  // Beats in the next burst: whatever is left, but never more than max_len.
  function automatic logic [8:0] burst_beats(input logic [31:0] rem, input logic [8:0] max_len);
    return (rem > 32'(max_len)) ? max_len : 9'(rem);
  endfunction

endpackage

// File: rtl/feat_axi_writer.sv
// Writes packed 512-bit feature words to DDR as AXI4 INCR bursts, one burst
// outstanding at a time, and paces the upstream reader one word at a time.
//
// Ports
//   aclk, arest_n          clock, asynchronous active-low reset
//   start                  one-cycle frame request (ignored while busy)
//   base_addr              1 KB aligned frame base byte address
//   total_beats            number of words in the frame (0 = empty frame)
//   busy / err / wr_done   status: frame in progress, sticky error, done pulse
//   res_start              pulse that triggers the first upstream read
//   w_handshake            pulse per accepted W beat (requests the next word)
//   res_data(_valid)       upstream word and its one-cycle valid strobe
//   m_axi_aw* / w* / b*    AXI4 write master channels
module feat_axi_writer
  import feat_wr_pkg::*;
#(
  parameter int unsigned AXI_DW    = 512,
  parameter int unsigned AXI_AW    = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  aclk,
  input  logic                  arest_n,
  input  logic                  start,
  input  logic [AXI_AW-1:0]     base_addr,
  input  logic [CNT_W-1:0]      total_beats,
  output logic                  busy,
  output logic                  err,
  output logic                  res_start,
  output logic                  w_handshake,
  output logic                  wr_done,
  input  logic [AXI_DW-1:0]     res_data,
  input  logic                  res_data_valid,
  output logic [AXI_AW-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [AXI_DW-1:0]     m_axi_wdata,
  output logic [AXI_DW/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  wr_state_e          state_q, state_d;
  logic [AXI_AW-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [8:0]         beat_q, beat_d;     // beats still to send in this burst
  logic [8:0]         blen_q, blen_d;     // size of this burst, for the address step
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               res_start_q, res_start_d;
  logic               w_hs_q, w_hs_d;
  logic               wr_done_q, wr_done_d;
  logic               buf_full_q, buf_full_d;
  logic [AXI_DW-1:0]  buf_data_q, buf_data_d;

  logic [8:0]         cur_beats_s;
  logic               w_fire_s;
  logic               ovf_s;
  logic               err_fsm_s;

  assign cur_beats_s = burst_beats(32'(rem_q), 9'(BURST_LEN));
  assign w_fire_s    = m_axi_wvalid && m_axi_wready;

  // AW payload is a pure function of registers, so it holds until awready.
  assign m_axi_awvalid = (state_q == ADDR);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = (state_q == ADDR) ? 8'(cur_beats_s - 9'd1) : 8'd0;
  assign m_axi_awsize  = AXSIZE_64B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wvalid  = (state_q == DATA) && buf_full_q;
  assign m_axi_wdata   = buf_data_q;
  assign m_axi_wstrb   = {(AXI_DW/8){1'b1}};
  assign m_axi_wlast   = (state_q == DATA) && (beat_q == 9'd1);
  assign m_axi_bready  = (state_q == RESP);
  assign busy          = busy_q;
  assign err           = err_q;
  assign res_start     = res_start_q;
  assign w_handshake   = w_hs_q;
  assign wr_done       = wr_done_q;

  // One-entry word buffer: load on valid, empty on an accepted beat, drop on overflow.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    ovf_s      = 1'b0;
    if (res_data_valid) begin
      if (buf_full_q && !w_fire_s) begin
        ovf_s = 1'b1;
      end else begin
        buf_full_d = 1'b1;
        buf_data_d = res_data;
      end
    end else if (w_fire_s) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
  end

  // Writer FSM: next state, counters, address and status pulses.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    beat_d      = beat_q;
    blen_d      = blen_q;
    busy_d      = busy_q;
    err_fsm_s   = err_q;
    res_start_d = 1'b0;
    w_hs_d      = 1'b0;
    wr_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          rem_d     = total_beats;
          err_fsm_s = 1'b0;
          if (total_beats == {CNT_W{1'b0}}) begin
            // Empty frame: report done straight away, nothing is requested.
            state_d   = DONE;
            wr_done_d = 1'b1;
          end else begin
            state_d     = ADDR;
            busy_d      = 1'b1;
            res_start_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        beat_d = cur_beats_s;
        blen_d = cur_beats_s;
        if (m_axi_awready) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (w_fire_s) begin
          rem_d  = rem_q - CNT_W'(1);
          beat_d = beat_q - 9'd1;
          w_hs_d = 1'b1;
          if (beat_q == 9'd1) begin
            state_d = RESP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          // An error response is recorded but the frame keeps going.
          if (m_axi_bresp != RESP_OKAY) begin
            err_fsm_s = 1'b1;
          end else begin
            err_fsm_s = err_q;
          end
          addr_d = addr_q + AXI_AW'({blen_q, 6'b000000});
          if (rem_q == {CNT_W{1'b0}}) begin
            state_d   = DONE;
            wr_done_d = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end else begin
          state_d = RESP;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Overflow wins over the clear-on-start so it is never lost.
    err_d = err_fsm_s | ovf_s;
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state_q     <= IDLE;
      addr_q      <= {AXI_AW{1'b0}};
      rem_q       <= {CNT_W{1'b0}};
      beat_q      <= 9'd0;
      blen_q      <= 9'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      res_start_q <= 1'b0;
      w_hs_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_data_q  <= {AXI_DW{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      beat_q      <= beat_d;
      blen_q      <= blen_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      res_start_q <= res_start_d;
      w_hs_q      <= w_hs_d;
      wr_done_q   <= wr_done_d;
      buf_full_q  <= buf_full_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule
